// File: rtl/ethpipe_pkg.sv
// rtl/ethpipe_pkg.sv - shared constants, FSM encoding and header layout for the GMII receive slot writer
package ethpipe_pkg;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t ST_IDLE     = 3'd0;
   localparam rx_state_t ST_PREAMBLE = 3'd1;
   localparam rx_state_t ST_DATA     = 3'd2;
   localparam rx_state_t ST_FLUSH    = 3'd3;
   localparam rx_state_t ST_HEADER   = 3'd4;
   localparam rx_state_t ST_DROP     = 3'd5;

   localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
   localparam logic [7:0]  SFD_BYTE        = 8'hD5;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hC704_DD7B;

   localparam int HDR_LEN_LSB     = 0;
   localparam int HDR_LEN_W       = 16;
   localparam int HDR_FCS_ERR_BIT = 16;
   localparam int HDR_TRUNC_BIT   = 17;

   // The CRC register is kept LSB-first, so the residue is compared bit-reversed.
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   function automatic logic [3:0] partial_byte_en(input logic [1:0] filled);
      case (filled)
         2'd1:    return 4'b0001;
         2'd2:    return 4'b0011;
         2'd3:    return 4'b0111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/gmii_rx_slot_writer_if.sv
// rtl/gmii_rx_slot_writer_if.sv - slot memory write port and frame-complete strobe
interface gmii_rx_slot_writer_if #(
   parameter int SLOT_AW = 11
);
   logic [31:0]        slot_rx_eth_data;
   logic [3:0]         slot_rx_eth_byte_en;
   logic [SLOT_AW-1:0] slot_rx_eth_address;
   logic               slot_rx_eth_wr_en;
   logic               rx_complete;

   modport master (
      output slot_rx_eth_data, slot_rx_eth_byte_en, slot_rx_eth_address,
             slot_rx_eth_wr_en, rx_complete
   );

   modport slave (
      input  slot_rx_eth_data, slot_rx_eth_byte_en, slot_rx_eth_address,
             slot_rx_eth_wr_en, rx_complete
   );
endinterface

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational reflected CRC32 next-state, one byte per step
module crc32_d8
   import ethpipe_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);
   logic [31:0] c;

   always_comb begin
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC32_POLY_REFL : 32'h0);
      end
   end

   assign crc_out = c;
endmodule

// File: rtl/gmii_rx_slot_writer.sv
// rtl/gmii_rx_slot_writer.sv - packs GMII receive bytes into slot words, then writes a length/status header at word 0
// FCS checking is built only when RX_FCS_CHECK_EN is defined.
module gmii_rx_slot_writer
   import ethpipe_pkg::*;
#(
   parameter int SLOT_AW = 11,
   parameter int MIN_LEN = 64
)(
   input  logic                         gmii_rx_clk,
   input  logic                         sys_rst,
   input  logic [7:0]                   gmii_rxd,
   input  logic                         gmii_rx_dv,
   input  logic                         rx_empty,
   gmii_rx_slot_writer_if.master        slot
);
   localparam int CNT_W = SLOT_AW + 2;
   // Word 0 is the header, so data may use every word but one.
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(4 * ((1 << SLOT_AW) - 1));

   rx_state_t          state_q, state_d;
   logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [23:0]        lanes_q, lanes_d;
   logic               trunc_q, trunc_d;
   logic               fcs_err_q, fcs_err_d;
   logic [31:0]        data_q, data_d;
   logic [3:0]         be_q, be_d;
   logic [SLOT_AW-1:0] addr_q, addr_d;
   logic               wr_en_q, wr_en_d;
   logic               complete_q, complete_d;
   logic [SLOT_AW-1:0] word_addr;
   logic [31:0]        hdr;

`ifdef RX_FCS_CHECK_EN
   logic [31:0] crc_q, crc_d, crc_next;

   crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (gmii_rxd),
      .crc_out (crc_next)
   );
`endif

   assign word_addr = byte_cnt_q[CNT_W-1:2] + SLOT_AW'(1);

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      lanes_d    = lanes_q;
      trunc_d    = trunc_q;
      fcs_err_d  = fcs_err_q;
      data_d     = data_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wr_en_d    = 1'b0;
      complete_d = 1'b0;
`ifdef RX_FCS_CHECK_EN
      crc_d      = crc_q;
`endif
      hdr = '0;
      hdr[HDR_LEN_LSB +: HDR_LEN_W] = HDR_LEN_W'(byte_cnt_q);
      hdr[HDR_FCS_ERR_BIT]          = fcs_err_q;
      hdr[HDR_TRUNC_BIT]            = trunc_q;

      case (state_q)
         ST_IDLE: begin
            if (gmii_rx_dv) state_d = (gmii_rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
         end
         ST_PREAMBLE: begin
            if (!gmii_rx_dv) begin
               state_d = ST_IDLE;
            end else if (gmii_rxd == SFD_BYTE && rx_empty) begin
               state_d    = ST_DATA;
               byte_cnt_d = '0;
               lanes_d    = '0;
               trunc_d    = 1'b0;
               fcs_err_d  = 1'b0;
`ifdef RX_FCS_CHECK_EN
               crc_d      = CRC32_INIT;
`endif
            end else if (gmii_rxd != PREAMBLE_BYTE) begin
               state_d = ST_DROP;
            end
         end
         ST_DATA: begin
            if (gmii_rx_dv) begin
`ifdef RX_FCS_CHECK_EN
               crc_d = crc_next;
`endif
               if (byte_cnt_q == MAX_CNT) begin
                  trunc_d = 1'b1;
               end else begin
                  byte_cnt_d = byte_cnt_q + CNT_W'(1);
                  case (byte_cnt_q[1:0])
                     2'd0: lanes_d[7:0]   = gmii_rxd;
                     2'd1: lanes_d[15:8]  = gmii_rxd;
                     2'd2: lanes_d[23:16] = gmii_rxd;
                     default: begin
                        wr_en_d = 1'b1;
                        data_d  = {gmii_rxd, lanes_q};
                        be_d    = 4'hF;
                        addr_d  = word_addr;
                     end
                  endcase
               end
            end else begin
               state_d = ST_FLUSH;
`ifdef RX_FCS_CHECK_EN
               fcs_err_d = (crc_q != reflect32(CRC32_RESIDUE));
`endif
               if (byte_cnt_q[1:0] != 2'd0) begin
                  wr_en_d = 1'b1;
                  data_d  = {8'h00, lanes_q};
                  be_d    = partial_byte_en(byte_cnt_q[1:0]);
                  addr_d  = word_addr;
               end
            end
         end
         ST_FLUSH: begin
            if (byte_cnt_q >= CNT_W'(MIN_LEN)) begin
               state_d = ST_HEADER;
               wr_en_d = 1'b1;
               data_d  = hdr;
               be_d    = 4'hF;
               addr_d  = '0;
            end else begin
               state_d = gmii_rx_dv ? ST_DROP : ST_IDLE;
            end
         end
         ST_HEADER: begin
            complete_d = 1'b1;
            state_d    = gmii_rx_dv ? ST_DROP : ST_IDLE;
         end
         ST_DROP: begin
            if (!gmii_rx_dv) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge gmii_rx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= '0;
         lanes_q    <= '0;
         trunc_q    <= 1'b0;
         fcs_err_q  <= 1'b0;
         data_q     <= '0;
         be_q       <= '0;
         addr_q     <= '0;
         wr_en_q    <= 1'b0;
         complete_q <= 1'b0;
`ifdef RX_FCS_CHECK_EN
         crc_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         lanes_q    <= lanes_d;
         trunc_q    <= trunc_d;
         fcs_err_q  <= fcs_err_d;
         data_q     <= data_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         wr_en_q    <= wr_en_d;
         complete_q <= complete_d;
`ifdef RX_FCS_CHECK_EN
         crc_q      <= crc_d;
`endif
      end
   end

   assign slot.slot_rx_eth_data    = data_q;
   assign slot.slot_rx_eth_byte_en = be_q;
   assign slot.slot_rx_eth_address = addr_q;
   assign slot.slot_rx_eth_wr_en   = wr_en_q;
   assign slot.rx_complete         = complete_q;
endmodule

// File: tb/tb_gmii_rx_slot_writer.sv
// tb/tb_gmii_rx_slot_writer.sv - scoreboard bench for gmii_rx_slot_writer
module tb_gmii_rx_slot_writer;
   localparam int SLOT_AW = 11;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rxd;
   logic       dv;
   logic       rx_empty;

   gmii_rx_slot_writer_if #(.SLOT_AW(SLOT_AW)) slot_bus ();

   gmii_rx_slot_writer #(.SLOT_AW(SLOT_AW), .MIN_LEN(64)) dut (
      .gmii_rx_clk (clk),
      .sys_rst     (rst),
      .gmii_rxd    (rxd),
      .gmii_rx_dv  (dv),
      .rx_empty    (rx_empty),
      .slot        (slot_bus)
   );

   always #4 clk = ~clk;

   typedef struct {
      logic [SLOT_AW-1:0] addr;
      logic [31:0]        data;
      logic [3:0]         be;
   } wr_t;

   wr_t        exp_q[$];
   int         exp_cmpl = 0;
   int         checks = 0;
   int         errors = 0;
   int         wr_seen = 0;
   int         cmpl_seen = 0;
   logic [7:0] frame[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a write or completion.
   always @(negedge clk) begin : monitor
      wr_t         e;
      logic [31:0] m;
      if (slot_bus.slot_rx_eth_wr_en === 1'b1) begin
         wr_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, expected no write",
                     slot_bus.slot_rx_eth_address, slot_bus.slot_rx_eth_data);
         end else begin
            e = exp_q.pop_front();
            m = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
            check("wr_addr", 32'(slot_bus.slot_rx_eth_address), 32'(e.addr));
            check("wr_byte_en", 32'(slot_bus.slot_rx_eth_byte_en), 32'(e.be));
            check("wr_data", slot_bus.slot_rx_eth_data & m, e.data & m);
         end
      end
      if (slot_bus.rx_complete === 1'b1) begin
         cmpl_seen++;
         checks++;
         if (exp_cmpl == 0) begin
            errors++;
            $display("FAIL unexpected_complete: got rx_complete=1, expected 0");
         end else begin
            exp_cmpl--;
         end
      end
   end

   function automatic logic [31:0] crc_model();
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (frame[i]) begin
         for (int b = 0; b < 8; b++) begin
            c = (c >> 1) ^ ((c[0] ^ frame[i][b]) ? 32'hEDB8_8320 : 32'h0);
         end
      end
      return c;
   endfunction

   task automatic build_frame(input int ndata, input int seed);
      logic [31:0] fcs;
      frame.delete();
      for (int i = 0; i < ndata; i++) frame.push_back(8'(i + seed));
      fcs = ~crc_model();
      for (int k = 0; k < 4; k++) frame.push_back(fcs[8*k +: 8]);
   endtask

   task automatic push_expect(input int nacc, input logic [31:0] hdr, input bit has_hdr);
      wr_t e;
      int  rem;
      for (int w = 0; w < nacc / 4; w++) begin
         e.addr = SLOT_AW'(w + 1);
         e.data = {frame[4*w+3], frame[4*w+2], frame[4*w+1], frame[4*w]};
         e.be   = 4'hF;
         exp_q.push_back(e);
      end
      rem = nacc % 4;
      if (rem != 0) begin
         e.addr = SLOT_AW'(nacc / 4 + 1);
         e.data = '0;
         for (int k = 0; k < rem; k++) e.data[8*k +: 8] = frame[4*(nacc/4) + k];
         e.be   = 4'((1 << rem) - 1);
         exp_q.push_back(e);
      end
      if (has_hdr) begin
         e.addr = '0;
         e.data = hdr;
         e.be   = 4'hF;
         exp_q.push_back(e);
         exp_cmpl++;
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      @(posedge clk);
      #1;
      dv  = v;
      rxd = d;
   endtask

   task automatic send_preamble(input bit empty);
      rx_empty = empty;
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
      drive(1'b1, 8'hD5);
   endtask

   task automatic send_tail();
      repeat (12) drive(1'b0, 8'h00);
      rx_empty = 1'b1;
   endtask

   task automatic run_frame(input string tag, input int ndata, input int seed, input bit empty,
                            input int flip, input int nacc, input logic [31:0] hdr,
                            input int exp_wr, input int exp_c);
      int w0, c0;
      build_frame(ndata, seed);
      if (flip >= 0) frame[flip] = frame[flip] ^ 8'h01;
      if (empty) push_expect(nacc, hdr, exp_c != 0);
      w0 = wr_seen;
      c0 = cmpl_seen;
      send_preamble(empty);
      foreach (frame[i]) drive(1'b1, frame[i]);
      send_tail();
      check({tag, "_write_count"}, 32'(wr_seen - w0), 32'(exp_wr));
      check({tag, "_complete_count"}, 32'(cmpl_seen - c0), 32'(exp_c));
   endtask

   initial begin
      int w0, c0;
      logic [31:0] flip_hdr;
      rst = 1'b1;
      dv = 1'b0;
      rxd = 8'h00;
      rx_empty = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_wr_en", 32'(slot_bus.slot_rx_eth_wr_en), 32'h0);
      check("reset_complete", 32'(slot_bus.rx_complete), 32'h0);
      check("reset_data", slot_bus.slot_rx_eth_data, 32'h0);
      check("reset_addr", 32'(slot_bus.slot_rx_eth_address), 32'h0);
      rst = 1'b0;
      repeat (2) drive(1'b0, 8'h00);

      // run_frame(tag, ndata, seed, rx_empty, flip, accepted, header, writes, completes)
      run_frame("f64",     60, 1, 1'b1, -1, 64, 32'h0000_0040, 17, 1);
      run_frame("f67",     63, 2, 1'b1, -1, 67, 32'h0000_0043, 18, 1);
      run_frame("busy",    60, 3, 1'b0, -1,  0, 32'h0,          0, 0);
      run_frame("runt",    36, 4, 1'b1, -1, 40, 32'h0,         10, 0);
      run_frame("post_rt", 60, 5, 1'b1, -1, 64, 32'h0000_0040, 17, 1);
`ifdef RX_FCS_CHECK_EN
      flip_hdr = 32'h0001_0040;
`else
      flip_hdr = 32'h0000_0040;
`endif
      run_frame("fcsflip", 60, 6, 1'b1, 10, 64, flip_hdr,      17, 1);
      run_frame("ovf",   8196, 7, 1'b1, -1, 8188, 32'h0002_1FFC, 2048, 1);

      // Reset mid-DATA: only words 1 and 2 land before the reset.
      build_frame(60, 0);
      push_expect(8, 32'h0, 1'b0);
      w0 = wr_seen;
      c0 = cmpl_seen;
      send_preamble(1'b1);
      foreach (frame[i]) begin
         drive(1'b1, frame[i]);
         if (i == 10) begin
            rst = 1'b1;
            #1;
            check("midrst_wr_en", 32'(slot_bus.slot_rx_eth_wr_en), 32'h0);
            check("midrst_data", slot_bus.slot_rx_eth_data, 32'h0);
            check("midrst_byte_en", 32'(slot_bus.slot_rx_eth_byte_en), 32'h0);
         end
         if (i == 12) rst = 1'b0;
      end
      send_tail();
      check("midrst_write_count", 32'(wr_seen - w0), 32'd2);
      check("midrst_complete_count", 32'(cmpl_seen - c0), 32'd0);
      run_frame("post_rst", 60, 8, 1'b1, -1, 64, 32'h0000_0040, 17, 1);

      repeat (20) @(posedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      check("completes_drained", 32'(exp_cmpl), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
